shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; fixed at 8 to match eight_bit_adder.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  8  multiplicand, unsigned.
REQ-006 SHALL have port b  input  8  multiplier, unsigned.
REQ-007 SHALL have port busy  output  1  high while state is CALC.
REQ-008 SHALL have port done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port product  output  16  registered unsigned result a*b.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 SHALL, in IDLE with start=1, capture a and b, clear the upper product half, clear the iteration counter, and enter CALC on that edge.
REQ-012 SHALL, in each CALC cycle, add the multiplicand to the upper product byte via eight_bit_adder with carry_in=0 when the current multiplier LSB=1 (add 0 otherwise), then shift {carry_out, sum, lower byte} right by one.
REQ-013 SHALL run exactly 8 CALC cycles, using a 3-bit counter that wraps 7->0 on the last iteration, then enter DONE.
REQ-014 SHALL assert done for exactly one cycle in DONE, starting 8 edges after the edge that sampled start, then return to IDLE.
REQ-015 SHALL hold product stable from DONE until the next accepted start; product is undefined-for-use while busy=1.
REQ-016 SHALL ignore start in CALC and DONE; no queuing.
REQ-017 SHALL ignore operand changes after capture.
REQ-018 SHALL never overflow: 255*255=0xFE01 fits in 16 bits.

Reset
REQ-019 SHALL, on rst_n=0 at any time including mid-CALC, abort, force IDLE, and set busy=0, done=0, product=0x0000, counter=0, captured operands=0.
REQ-020 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-021 SHALL, with macro SHIFT_ADD_MULTIPLIER_MAC_EN defined, add input acc_clr (1), output acc (16) and output acc_ovf (1): in DONE, acc <= acc + product modulo 2^16, and acc_ovf is set sticky on carry out of bit 15; acc_clr=1 clears acc and acc_ovf synchronously, with priority over accumulation; both reset to 0.
REQ-022 SHALL, without the macro, omit those ports and the accumulator logic entirely; the remaining behaviour is identical.

Structure
REQ-023 SHALL keep FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2), WIDTH and ITER_COUNT=8 in a shared package/header included by RTL and bench.
REQ-024 SHALL instantiate exactly one eight_bit_adder sub-module for the per-iteration add; no behavioural '+' on the datapath, except for the MAC accumulator.

Verification
REQ-025 SHALL cover: a=13, b=11, start pulse -> busy for 8 cycles, done pulse 8 edges later, product=143.
REQ-026 SHALL cover: a=0xFF, b=0xFF -> product=0xFE01; a=0x00, b=0xFF -> product=0x0000, with unchanged latency.
REQ-027 SHALL cover: start with a=200, b=3, then start with a=1, b=1 on cycle 4 of CALC -> second start ignored, product=600.
REQ-028 SHALL cover: rst_n pulled low at cycle 5 of CALC -> busy=0, done=0, product=0 immediately; a new start after release with a=7, b=9 -> 63.
REQ-029 SHALL cover (MAC_EN): acc_clr, then two ops of 200*200 -> acc=40000 then 14464, with acc_ovf=1 after the second; acc_clr -> acc=0, acc_ovf=0.
REQ-030 SHALL cover: back-to-back starts (start held high) -> a new op accepted in each IDLE cycle, with one done per op and a 10-cycle period.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_pkg
// Shared constants and types for the shift-and-add multiplier, used by the RTL
// and by the testbench.
//   WIDTH      : operand width (the per-iteration adder is fixed at 8 bits)
//   ITER_COUNT : number of CALC iterations, one per multiplier bit
//   CNT_W      : width of the iteration counter
//   state_e    : FSM state encoding
// -----------------------------------------------------------------------------
package shift_add_multiplier_pkg;

   localparam int WIDTH      = 8;
   localparam int ITER_COUNT = 8;
   localparam int CNT_W      = $clog2(ITER_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_if
// Request/result bundle of the multiplier.
//   start   : request, sampled only while the multiplier is idle
//   a, b    : unsigned multiplicand / multiplier
//   busy    : high while iterating
//   done    : one-cycle pulse, product valid
//   product : registered unsigned result a*b
// With SHIFT_ADD_MULTIPLIER_MAC_EN defined the bundle also carries:
//   acc_clr : synchronous clear of the accumulator and its overflow flag
//   acc     : running sum of products, modulo 2^16
//   acc_ovf : sticky carry out of the accumulator
// Modports: master drives requests, slave (the multiplier) drives results.
// -----------------------------------------------------------------------------
interface shift_add_multiplier_if;
   import shift_add_multiplier_pkg::*;

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

`ifdef SHIFT_ADD_MULTIPLIER_MAC_EN
   logic                 acc_clr;
   logic [2*WIDTH-1:0]   acc;
   logic                 acc_ovf;

   modport master (output start, a, b, acc_clr,
                   input  busy, done, product, acc, acc_ovf);
   modport slave  (input  start, a, b, acc_clr,
                   output busy, done, product, acc, acc_ovf);
`else
   modport master (output start, a, b,
                   input  busy, done, product);
   modport slave  (input  start, a, b,
                   output busy, done, product);
`endif

endinterface

// File: rtl/shift_add_multiplier_eight_bit_adder.sv
// -----------------------------------------------------------------------------
// eight_bit_adder
// Purely combinational 8-bit ripple-carry adder built from full-adder cells.
//   a_i, b_i    : addends
//   carry_in_i  : carry into bit 0
//   sum_o       : 8-bit sum
//   carry_out_o : carry out of bit 7
// -----------------------------------------------------------------------------
module eight_bit_adder (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       carry_in_i,
   output logic [7:0] sum_o,
   output logic       carry_out_o
);

   logic [8:0] carry;

   assign carry[0] = carry_in_i;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign carry_out_o = carry[8];

endmodule

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned multiplier: one shift-and-add step per clock, eight
// steps per product. FSM IDLE -> CALC (8 cycles) -> DONE (1 cycle) -> IDLE.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any operation
//   bus   : shift_add_multiplier_if.slave (start/a/b in, busy/done/product out)
// Optional feature: define SHIFT_ADD_MULTIPLIER_MAC_EN to add a product
// accumulator (acc_clr in, acc/acc_ovf out on the same interface).
//
// Datapath: prod_q holds {partial sum, remaining multiplier bits}. The lower
// half is loaded with b; each step adds the multiplicand to the upper half when
// prod_q[0] is set and shifts {carry, sum, lower} right by one, so after eight
// steps prod_q holds a*b.
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   shift_add_multiplier_if.slave bus
);
   import shift_add_multiplier_pkg::*;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [WIDTH-1:0]     add_addend;
   logic [WIDTH-1:0]     add_sum;
   logic                 add_carry;

   // Add the multiplicand or zero, depending on the current multiplier bit.
   assign add_addend = prod_q[0] ? mcand_q : '0;

   eight_bit_adder u_adder (
      .a_i         (prod_q[2*WIDTH-1:WIDTH]),
      .b_i         (add_addend),
      .carry_in_i  (1'b0),
      .sum_o       (add_sum),
      .carry_out_o (add_carry)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end

   // NOTE: every variable gets its hold value first, so no path through the
   // case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.a;
               prod_d  = {{WIDTH{1'b0}}, bus.b};
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            prod_d = {add_carry, add_sum, prod_q[WIDTH-1:1]};
            // Counter wraps back to zero on the last iteration.
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy    = (state_q == CALC);
   assign bus.done    = (state_q == DONE);
   assign bus.product = prod_q;

`ifdef SHIFT_ADD_MULTIPLIER_MAC_EN
   logic [2*WIDTH-1:0] acc_q;
   logic               acc_ovf_q;
   logic [2*WIDTH:0]   acc_sum;

   // One extra bit captures the carry out of the accumulator's top bit.
   assign acc_sum = {1'b0, acc_q} + {1'b0, prod_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
      end else if (bus.acc_clr) begin
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
      end else if (state_q == DONE) begin
         acc_q     <= acc_sum[2*WIDTH-1:0];
         acc_ovf_q <= acc_ovf_q | acc_sum[2*WIDTH];
      end
   end

   assign bus.acc     = acc_q;
   assign bus.acc_ovf = acc_ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
// Directed testbench for shift_add_multiplier. Inputs change and outputs are
// sampled 1 time unit after each rising edge. Define
// SHIFT_ADD_MULTIPLIER_MAC_EN to include the accumulator scenario.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;
   import shift_add_multiplier_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   shift_add_multiplier_if bus ();

   shift_add_multiplier #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests_run = 0;
   int failures  = 0;
   int cyc       = 0;
   int done_seen = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.done === 1'b1) done_seen <= done_seen + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done, counting edges taken and cycles seen busy.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.busy === 1'b1) busy_cnt++;
         step();
         lat++;
      end
   endtask

   // One complete operation from IDLE, back to IDLE one edge after done.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
      int lat, bc;
      bus.a = a; bus.b = b; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done(lat, bc);
      tests_run++;
      if (lat !== 8) begin
         failures++;
         $display("FAIL %s latency: got %0d edges, expected 8", name, lat);
      end
      tests_run++;
      if (bc !== 8) begin
         failures++;
         $display("FAIL %s busy cycles: got %0d, expected 8", name, bc);
      end
      tests_run++;
      if (bus.product !== exp) begin
         failures++;
         $display("FAIL %s product: got %h, expected %h", name, bus.product, exp);
      end
      step();
      tests_run++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL %s done width: done=%b one cycle later, expected 0", name, bus.done);
      end
      tests_run++;
      if (bus.product !== exp) begin
         failures++;
         $display("FAIL %s product hold: got %h, expected %h", name, bus.product, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
`ifdef SHIFT_ADD_MULTIPLIER_MAC_EN
      bus.acc_clr = 1'b0;
`endif
      step(); step();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
         failures++;
         $display("FAIL reset state: busy=%b done=%b product=%h, expected 0 0 0000",
                  bus.busy, bus.done, bus.product);
      end
`ifdef SHIFT_ADD_MULTIPLIER_MAC_EN
      tests_run++;
      if (bus.acc !== 16'h0000 || bus.acc_ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset acc: acc=%h ovf=%b, expected 0000 0", bus.acc, bus.acc_ovf);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step(); step();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL idle without start: busy=%b done=%b, expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_basic();
      run_op(8'd13, 8'd11, 16'd143, "13x11");
   endtask

   task automatic test_extremes();
      run_op(8'hFF, 8'hFF, 16'hFE01, "FFxFF");
      run_op(8'h00, 8'hFF, 16'h0000, "00xFF");
      run_op(8'hFF, 8'h00, 16'h0000, "FFx00");
   endtask

   task automatic test_ignore_start();
      int lat, bc;
      bus.a = 8'd200; bus.b = 8'd3; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      // Fourth CALC cycle: new request and new operands must be ignored.
      bus.a = 8'd1; bus.b = 8'd1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done(lat, bc);
      tests_run++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL ignore_start latency: done after %0d more edges, expected 4", lat);
      end
      tests_run++;
      if (bus.product !== 16'd600) begin
         failures++;
         $display("FAIL ignore_start product: got %0d, expected 600", bus.product);
      end
      step(); step();
      tests_run++;
      if (bus.busy !== 1'b0 || bus.product !== 16'd600) begin
         failures++;
         $display("FAIL ignore_start no queue: busy=%b product=%0d, expected 0 600",
                  bus.busy, bus.product);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      bus.a = 8'd50; bus.b = 8'd77; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step(); step(); step();
      tests_run++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid precondition: busy=%b, expected 1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
         failures++;
         $display("FAIL reset_mid abort: busy=%b done=%b product=%h, expected 0 0 0000",
                  bus.busy, bus.done, bus.product);
      end
      bus.a = 8'd7; bus.b = 8'd9; bus.start = 1'b1;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      bus.start = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid first edge: busy=%b, expected 1", bus.busy);
      end
      wait_done(lat, bc);
      tests_run++;
      if (lat !== 8 || bus.product !== 16'd63) begin
         failures++;
         $display("FAIL reset_mid 7x9: latency=%0d product=%0d, expected 8 63", lat, bus.product);
      end
      step();
   endtask

`ifdef SHIFT_ADD_MULTIPLIER_MAC_EN
   task automatic test_mac();
      bus.acc_clr = 1'b1;
      step();
      bus.acc_clr = 1'b0;
      tests_run++;
      if (bus.acc !== 16'd0 || bus.acc_ovf !== 1'b0) begin
         failures++;
         $display("FAIL mac clear: acc=%0d ovf=%b, expected 0 0", bus.acc, bus.acc_ovf);
      end
      run_op(8'd200, 8'd200, 16'd40000, "mac op1");
      tests_run++;
      if (bus.acc !== 16'd40000 || bus.acc_ovf !== 1'b0) begin
         failures++;
         $display("FAIL mac op1 acc: acc=%0d ovf=%b, expected 40000 0", bus.acc, bus.acc_ovf);
      end
      run_op(8'd200, 8'd200, 16'd40000, "mac op2");
      tests_run++;
      if (bus.acc !== 16'd14464 || bus.acc_ovf !== 1'b1) begin
         failures++;
         $display("FAIL mac op2 acc: acc=%0d ovf=%b, expected 14464 1", bus.acc, bus.acc_ovf);
      end
      bus.acc_clr = 1'b1;
      step();
      bus.acc_clr = 1'b0;
      tests_run++;
      if (bus.acc !== 16'd0 || bus.acc_ovf !== 1'b0) begin
         failures++;
         $display("FAIL mac final clear: acc=%0d ovf=%b, expected 0 0", bus.acc, bus.acc_ovf);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [7:0]  va [3] = '{8'd3, 8'd100, 8'd255};
      logic [7:0]  vb [3] = '{8'd5, 8'd2,   8'd1};
      logic [15:0] vp [3] = '{16'd15, 16'd200, 16'd255};
      int lat, bc, done_cyc, prev_cyc, seen0;
      prev_cyc = 0;
      seen0    = done_seen;
      bus.start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.a = va[k]; bus.b = vb[k];
         step();
         tests_run++;
         if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b op%0d accept: busy=%b, expected 1", k, bus.busy);
         end
         wait_done(lat, bc);
         done_cyc = cyc;
         tests_run++;
         if (lat !== 8 || bus.product !== vp[k]) begin
            failures++;
            $display("FAIL b2b op%0d: latency=%0d product=%0d, expected 8 %0d",
                     k, lat, bus.product, vp[k]);
         end
         if (k > 0) begin
            tests_run++;
            if (done_cyc - prev_cyc !== 10) begin
               failures++;
               $display("FAIL b2b period op%0d: got %0d cycles, expected 10", k, done_cyc - prev_cyc);
            end
         end
         prev_cyc = done_cyc;
         step();
      end
      bus.start = 1'b0;
      step();
      tests_run++;
      if (bus.busy !== 1'b0 || done_seen - seen0 !== 3) begin
         failures++;
         $display("FAIL b2b end: busy=%b done pulses=%0d, expected 0 3", bus.busy, done_seen - seen0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_ignore_start();
      test_reset_mid();
`ifdef SHIFT_ADD_MULTIPLIER_MAC_EN
      test_mac();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
